// File: rtl/dmem_responder.sv
// Data-memory responder for the load/store unit: byte-enable word array, optional wait states,
// fixed read latency. Define DMEM_RESP_PARITY_EN to store per-byte even parity and flag load mismatches.
module dmem_responder #(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1,
  parameter int WAIT_STATES  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data_w,
  input  logic [3:0]            be,
  output logic [31:0]           data_r,
  output logic                  resp_valid,
  output logic                  delay,
  output logic                  parity_err
);

  localparam int         IDX_W     = ADDR_WIDTH - 2;
  localparam int         WORDS     = 2 ** IDX_W;
  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS
  } state_t;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] data;
  } rd_stage_t;

  state_t             state_q, state_d;
  logic [3:0]         wait_cnt;
  logic               accept;
  logic               load_fire;
  logic               req_we;
  logic [IDX_W-1:0]   req_idx;
  logic [31:0]        req_data;
  logic [3:0]         req_be;
  logic [31:0]        mem [WORDS];
  logic [31:0]        rd_word;
  logic               rd_err;
  rd_stage_t          pipe [READ_LATENCY];

  // Word access only: the byte offset carries no information.
  logic addr_unused;
  assign addr_unused = ^addr[1:0];

  assign delay     = (state_q == ST_WAIT) || ((state_q == ST_ACCESS) && HAS_WAIT);
  assign accept    = en && !delay;
  assign load_fire = (state_q == ST_ACCESS) && !req_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = HAS_WAIT ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (wait_cnt == 4'd0) state_d = ST_ACCESS;
      ST_ACCESS: begin
        // Only reachable with zero wait states, where back-to-back requests chain accesses.
        state_d = ST_IDLE;
        if (accept) state_d = HAS_WAIT ? ST_WAIT : ST_ACCESS;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 4'd0;
    end else if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) begin
      wait_cnt <= WAIT_INIT;
    end else if ((state_q == ST_WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_we   <= 1'b0;
      req_idx  <= '0;
      req_data <= '0;
      req_be   <= '0;
    end else if (accept) begin
      req_we   <= we;
      req_idx  <= addr[ADDR_WIDTH-1:2];
      req_data <= data_w;
      req_be   <= be;
    end
  end

`ifdef DMEM_RESP_PARITY_EN
  logic [3:0] mem_par [WORDS];

  function automatic logic [3:0] byte_par(input logic [31:0] w);
    for (int i = 0; i < 4; i++) byte_par[i] = ^w[8*i +: 8];
  endfunction

  always_ff @(posedge clk) begin
    if ((state_q == ST_ACCESS) && req_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) mem_par[req_idx][i] <= ^req_data[8*i +: 8];
      end
    end
  end

  assign rd_err = |(byte_par(rd_word) ^ mem_par[req_idx]);
`else
  assign rd_err = 1'b0;
`endif

  // NOTE: the array has no reset; its contents survive reset and it maps onto plain SRAM.
  always_ff @(posedge clk) begin
    if ((state_q == ST_ACCESS) && req_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) mem[req_idx][8*i +: 8] <= req_data[8*i +: 8];
      end
    end
  end

  assign rd_word = mem[req_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{vld: load_fire, err: rd_err, data: rd_word};
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r     <= '0;
      resp_valid <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      resp_valid <= pipe[READ_LATENCY-1].vld;
      parity_err <= pipe[READ_LATENCY-1].vld && pipe[READ_LATENCY-1].err;
      if (pipe[READ_LATENCY-1].vld) data_r <= pipe[READ_LATENCY-1].data;
    end
  end

endmodule
